pov_scheduler: RTL and testbench

Frame-synchronous controller for the point-of-view (POV) vector set: playerX/Y, facingX/Y and vplaneX/Y. Once per frame, at the frame-end strobe, it chooses between two update sources. A complete host SPI frame has priority. Otherwise, local motion requests step the player position along the facing or viewplane direction. The chosen result goes live in a single atomic commit. It sits between the SPI frame receiver / motion inputs and the live POV vector registers consumed by the tracer.

---
 rtl/pov_scheduler_pkg.sv | 46 ++++
 rtl/pov_axis_step.sv | 31 +++
 rtl/pov_scheduler.sv | 137 +++++++++++++
 tb/tb_pov_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pov_scheduler_pkg.sv
// Shared widths, frame field offsets, init constants and FSM encoding for the
// POV vector scheduler.
package pov_scheduler_pkg;

  localparam int PLAYER_W = 15;
  localparam int VEC_W    = 11;
  localparam int POV_BITS = 74;
  localparam int D_W      = 13;

  localparam int PX_LSB = 59;
  localparam int PY_LSB = 44;
  localparam int FX_LSB = 33;
  localparam int FY_LSB = 22;
  localparam int VX_LSB = 11;
  localparam int VY_LSB = 0;

  localparam logic [PLAYER_W-1:0] INIT_PLAYER_X = 15'h0300;
  localparam logic [PLAYER_W-1:0] INIT_PLAYER_Y = 15'h0300;
  localparam logic [VEC_W-1:0]    INIT_FACING_X = 11'h000;
  localparam logic [VEC_W-1:0]    INIT_FACING_Y = 11'h200;
  localparam logic [VEC_W-1:0]    INIT_VPLANE_X = 11'h700;
  localparam logic [VEC_W-1:0]    INIT_VPLANE_Y = 11'h000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_MOVE_X = 3'd2,
    ST_MOVE_Y = 3'd3,
    ST_COMMIT = 3'd4
  } pov_state_e;

  // One direction component scaled by a +1/0/-1 request pair; opposing requests cancel.
  function automatic logic signed [D_W-1:0] dir_term(input logic [VEC_W-1:0] v,
                                                     input logic pos, input logic neg);
    logic signed [D_W-1:0] ext;
    ext = $signed({{(D_W-VEC_W){v[VEC_W-1]}}, v});
    if (pos && !neg) begin
      dir_term = ext;
    end else if (neg && !pos) begin
      dir_term = -ext;
    end else begin
      dir_term = '0;
    end
  endfunction

endpackage

// File: rtl/pov_axis_step.sv
// Adds a signed delta to an unsigned UQ6.9 position, saturating to [0, 64)
// or wrapping modulo 64 depending on CLAMP_EN.
module pov_axis_step
  import pov_scheduler_pkg::*;
#(
  parameter int CLAMP_EN = 1
) (
  input  logic [PLAYER_W-1:0] pos,
  input  logic [D_W-1:0]      delta,
  output logic [PLAYER_W-1:0] result
);

  logic [16:0] sum_s;

  // Bit 16 flags a negative result, bit 15 a result at or beyond 64.0.
  always_comb begin
    sum_s = {2'b00, pos} + {{(17-D_W){delta[D_W-1]}}, delta};
    if (CLAMP_EN != 0) begin
      if (sum_s[16]) begin
        result = 15'h0000;
      end else if (sum_s[15]) begin
        result = 15'h7FFF;
      end else begin
        result = sum_s[14:0];
      end
    end else begin
      result = sum_s[14:0];
    end
  end

endmodule

// File: rtl/pov_scheduler.sv
// Frame-synchronous POV vector scheduler: once per frame applies either a host
// frame or a local motion step, then commits atomically with o_load.
module pov_scheduler
  import pov_scheduler_pkg::*;
#(
  parameter int STEP_SHIFT = 3,
  parameter int CLAMP_EN   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_frame_end,
  input  logic                i_host_valid,
  input  logic [POV_BITS-1:0] i_host_data,
  output logic                o_host_ack,
  input  logic                i_mv_fwd,
  input  logic                i_mv_back,
  input  logic                i_mv_left,
  input  logic                i_mv_right,
  output logic [POV_BITS-1:0] o_vectors,
  output logic                o_load,
  output logic                o_busy,
  output logic                o_overrun
);

  pov_state_e state_r, state_s;

  logic [PLAYER_W-1:0] player_x_r, player_y_r;
  logic [VEC_W-1:0]    facing_x_r, facing_y_r, vplane_x_r, vplane_y_r;
  logic [D_W-1:0]      dx_r, dy_r;
  logic [D_W-1:0]      dx_s, dy_s;
  logic                motion_s;
  logic                host_ack_r, load_r, busy_r, overrun_r;
  logic [PLAYER_W-1:0] step_pos_s, step_res_s;
  logic [D_W-1:0]      step_delta_s;

  // Net direction D and whether any uncancelled request is present.
  always_comb begin
    motion_s = (i_mv_fwd ^ i_mv_back) | (i_mv_left ^ i_mv_right);
    dx_s = dir_term(facing_x_r, i_mv_fwd, i_mv_back) + dir_term(vplane_x_r, i_mv_right, i_mv_left);
    dy_s = dir_term(facing_y_r, i_mv_fwd, i_mv_back) + dir_term(vplane_y_r, i_mv_right, i_mv_left);
  end

  // The single step adder serves X in MOVE_X and Y in MOVE_Y.
  always_comb begin
    if (state_r == ST_MOVE_Y) begin
      step_pos_s   = player_y_r;
      step_delta_s = $signed(dy_r) >>> STEP_SHIFT;
    end else begin
      step_pos_s   = player_x_r;
      step_delta_s = $signed(dx_r) >>> STEP_SHIFT;
    end
  end

  pov_axis_step #(.CLAMP_EN(CLAMP_EN)) u_axis_step (
    .pos    (step_pos_s),
    .delta  (step_delta_s),
    .result (step_res_s)
  );

  // Next-state logic; host_ack_r doubles as the host-path decision in DECIDE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_frame_end) state_s = ST_DECIDE;
        else             state_s = ST_IDLE;
      end
      ST_DECIDE: begin
        if (host_ack_r)    state_s = ST_COMMIT;
        else if (motion_s) state_s = ST_MOVE_X;
        else               state_s = ST_IDLE;
      end
      ST_MOVE_X: state_s = ST_MOVE_Y;
      ST_MOVE_Y: state_s = ST_COMMIT;
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      host_ack_r <= 1'b0;
      load_r     <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      host_ack_r <= (state_r == ST_IDLE) && i_frame_end && i_host_valid;
      load_r     <= (state_s == ST_COMMIT);
      busy_r     <= (state_s != ST_IDLE);
      if (i_frame_end && (state_r != ST_IDLE)) overrun_r <= 1'b1;
    end
  end

  // Shadow vector set and latched motion direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      player_x_r <= INIT_PLAYER_X;
      player_y_r <= INIT_PLAYER_Y;
      facing_x_r <= INIT_FACING_X;
      facing_y_r <= INIT_FACING_Y;
      vplane_x_r <= INIT_VPLANE_X;
      vplane_y_r <= INIT_VPLANE_Y;
      dx_r       <= '0;
      dy_r       <= '0;
    end else begin
      case (state_r)
        ST_DECIDE: begin
          if (host_ack_r) begin
            player_x_r <= i_host_data[PX_LSB +: PLAYER_W];
            player_y_r <= i_host_data[PY_LSB +: PLAYER_W];
            facing_x_r <= i_host_data[FX_LSB +: VEC_W];
            facing_y_r <= i_host_data[FY_LSB +: VEC_W];
            vplane_x_r <= i_host_data[VX_LSB +: VEC_W];
            vplane_y_r <= i_host_data[VY_LSB +: VEC_W];
          end else begin
            dx_r <= dx_s;
            dy_r <= dy_s;
          end
        end
        ST_MOVE_X: player_x_r <= step_res_s;
        ST_MOVE_Y: player_y_r <= step_res_s;
        default: begin
        end
      endcase
    end
  end

  assign o_vectors  = {player_x_r, player_y_r, facing_x_r, facing_y_r, vplane_x_r, vplane_y_r};
  assign o_load     = load_r;
  assign o_host_ack = host_ack_r;
  assign o_busy     = busy_r;
  assign o_overrun  = overrun_r;

endmodule

// File: tb/tb_pov_scheduler.sv
// Self-checking bench for pov_scheduler: directed cases plus random frames,
// one clamping and one wrapping instance checked against a frame-level model.
module tb_pov_scheduler;

  localparam int STEP_SHIFT = 3;
  localparam logic [73:0] INIT = {15'h0300, 15'h0300, 11'h000, 11'h200, 11'h700, 11'h000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_frame_end = 1'b0;
  logic        i_host_valid = 1'b0;
  logic [73:0] i_host_data = '0;
  logic        i_mv_fwd = 1'b0, i_mv_back = 1'b0, i_mv_left = 1'b0, i_mv_right = 1'b0;

  logic        ack_c, load_c, busy_c, ovr_c;
  logic        ack_w, load_w, busy_w, ovr_w;
  logic [73:0] vec_c, vec_w;

  int errors = 0;
  int checks = 0;

  logic [73:0] exp_c, exp_w;
  bit          exp_ovr;

  always #5 clk = ~clk;

  pov_scheduler #(.STEP_SHIFT(STEP_SHIFT), .CLAMP_EN(1)) dut_c (
    .clk(clk), .reset(reset), .i_frame_end(i_frame_end), .i_host_valid(i_host_valid),
    .i_host_data(i_host_data), .o_host_ack(ack_c), .i_mv_fwd(i_mv_fwd), .i_mv_back(i_mv_back),
    .i_mv_left(i_mv_left), .i_mv_right(i_mv_right), .o_vectors(vec_c), .o_load(load_c),
    .o_busy(busy_c), .o_overrun(ovr_c));

  pov_scheduler #(.STEP_SHIFT(STEP_SHIFT), .CLAMP_EN(0)) dut_w (
    .clk(clk), .reset(reset), .i_frame_end(i_frame_end), .i_host_valid(i_host_valid),
    .i_host_data(i_host_data), .o_host_ack(ack_w), .i_mv_fwd(i_mv_fwd), .i_mv_back(i_mv_back),
    .i_mv_left(i_mv_left), .i_mv_right(i_mv_right), .o_vectors(vec_w), .o_load(load_w),
    .o_busy(busy_w), .o_overrun(ovr_w));

  task automatic chk(input string tag, input logic [73:0] got, input logic [73:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Frame-level model of one motion step: player += floor(D / 2^STEP_SHIFT).
  function automatic logic [73:0] mmove(input logic [73:0] v, input int nf, input int ns, input bit clamp);
    int fx, fy, vx, vy, dx, dy, px, py;
    logic [73:0] r;
    fx = int'($signed(v[43:33]));
    fy = int'($signed(v[32:22]));
    vx = int'($signed(v[21:11]));
    vy = int'($signed(v[10:0]));
    px = int'(v[73:59]);
    py = int'(v[58:44]);
    dx = (nf * fx + ns * vx) >>> STEP_SHIFT;
    dy = (nf * fy + ns * vy) >>> STEP_SHIFT;
    px = px + dx;
    py = py + dy;
    if (clamp) begin
      px = (px < 0) ? 0 : ((px > 32767) ? 32767 : px);
      py = (py < 0) ? 0 : ((py > 32767) ? 32767 : py);
    end else begin
      px = px & 32767;
      py = py & 32767;
    end
    r = v;
    r[73:59] = 15'(px);
    r[58:44] = 15'(py);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_c = INIT;
    exp_w = INIT;
    exp_ovr = 1'b0;
  endtask

  // One frame: pulse frame_end, watch cycles T+1..T+6, optionally pulse a second
  // frame_end in busy cycle 'extra', then compare against the model.
  task automatic run_frame(input bit hv, input logic [73:0] hd, input bit f, input bit b,
                           input bit l, input bit r, input int extra);
    int nf, ns, ack_n, ack_at, load_n, load_at, load_w_n, exp_load_at;
    logic busy1;
    logic [73:0] nc, nw;
    nf = int'(f) - int'(b);
    ns = int'(r) - int'(l);
    if (hv) begin
      nc = hd; nw = hd; exp_load_at = 2;
    end else if (nf != 0 || ns != 0) begin
      nc = mmove(exp_c, nf, ns, 1'b1); nw = mmove(exp_w, nf, ns, 1'b0); exp_load_at = 4;
    end else begin
      nc = exp_c; nw = exp_w; exp_load_at = 0;
    end
    ack_n = 0; ack_at = 0; load_n = 0; load_at = 0; load_w_n = 0; busy1 = 1'b0;
    @(negedge clk);
    i_host_valid = hv; i_host_data = hd;
    i_mv_fwd = f; i_mv_back = b; i_mv_left = l; i_mv_right = r;
    i_frame_end = 1'b1;
    @(negedge clk);
    i_frame_end = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) busy1 = busy_c;
      if (ack_c) begin ack_n++; ack_at = k; end
      if (load_c) begin load_n++; load_at = k; end
      if (load_w) load_w_n++;
      i_frame_end = (k == extra);
      if (k >= 2) i_host_valid = 1'b0;
    end
    i_mv_fwd = 1'b0; i_mv_back = 1'b0; i_mv_left = 1'b0; i_mv_right = 1'b0;
    if (extra != 0) exp_ovr = 1'b1;
    exp_c = nc;
    exp_w = nw;
    chk("ack_count", 74'(ack_n), 74'(hv ? 1 : 0));
    chk("ack_cycle", 74'(ack_at), 74'(hv ? 1 : 0));
    chk("load_count", 74'(load_n), 74'(exp_load_at != 0 ? 1 : 0));
    chk("load_cycle", 74'(load_at), 74'(exp_load_at));
    chk("load_count_wrap", 74'(load_w_n), 74'(exp_load_at != 0 ? 1 : 0));
    chk("vectors_clamp", vec_c, exp_c);
    chk("vectors_wrap", vec_w, exp_w);
    chk("busy_t1", 74'(busy1), 74'(1));
    chk("busy_after", 74'(busy_c), 74'(0));
    chk("overrun", 74'(ovr_c), 74'(exp_ovr));
    chk("overrun_wrap", 74'(ovr_w), 74'(exp_ovr));
  endtask

  initial begin
    logic [73:0] hd;
    int load_n, ack_n, sel, extra, blen;
    bit hv, f, b, l, r;
    logic [14:0] px, py;

    exp_c = INIT; exp_w = INIT; exp_ovr = 1'b0;
    do_reset();
    @(negedge clk);
    chk("reset_vectors", vec_c, INIT);
    chk("reset_vectors_wrap", vec_w, INIT);
    chk("reset_load", 74'(load_c), 74'(0));
    chk("reset_ack", 74'(ack_c), 74'(0));
    chk("reset_busy", 74'(busy_c), 74'(0));
    chk("reset_overrun", 74'(ovr_c), 74'(0));

    for (int i = 0; i < 3; i++) run_frame(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    run_frame(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("fwd_player_y", 74'(vec_c[58:44]), 74'(15'h0340));
    chk("fwd_player_x", 74'(vec_c[73:59]), 74'(15'h0300));

    run_frame(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("left_player_x", 74'(vec_c[73:59]), 74'(15'h0320));

    hd = {15'h1000, 15'h0300, 11'h000, 11'h200, 11'h700, 11'h000};
    run_frame(1'b1, hd, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("host_player_x", 74'(vec_c[73:59]), 74'(15'h1000));

    hd = {15'h0300, 15'h7FF0, 11'h000, 11'h200, 11'h700, 11'h000};
    run_frame(1'b1, hd, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("sat_player_y", 74'(vec_c[58:44]), 74'(15'h7FFF));
    chk("wrap_player_y", 74'(vec_w[58:44]), 74'(15'h0030));

    hd = {15'h0400, 15'h0500, 11'h100, 11'h000, 11'h000, 11'h100};
    run_frame(1'b1, hd, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("host_over_motion", vec_c, hd);
    chk("overrun_set", 74'(ovr_c), 74'(1));

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 2));
      px = 15'($urandom);
      py = 15'($urandom);
      if (sel == 1) begin px = 15'($urandom_range(0, 80)); py = 15'($urandom_range(0, 80)); end
      if (sel == 2) begin px = 15'(32767 - $urandom_range(0, 80)); py = 15'(32767 - $urandom_range(0, 80)); end
      hd = {px, py, 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom)};
      hv = ($urandom_range(0, 3) == 0);
      f = 1'($urandom); b = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
      blen = hv ? 2 : (((f ^ b) | (l ^ r)) ? 4 : 1);
      extra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, blen)) : 0;
      run_frame(hv, hd, f, b, l, r, extra);
    end

    // Reset in the middle of a motion sequence.
    @(negedge clk);
    i_mv_fwd = 1'b1;
    i_frame_end = 1'b1;
    @(negedge clk);
    i_frame_end = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_mv_fwd = 1'b0;
    exp_c = INIT; exp_w = INIT; exp_ovr = 1'b0;
    load_n = 0; ack_n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (load_c || load_w) load_n++;
      if (ack_c) ack_n++;
    end
    chk("midreset_load", 74'(load_n), 74'(0));
    chk("midreset_ack", 74'(ack_n), 74'(0));
    chk("midreset_vectors", vec_c, INIT);
    chk("midreset_vectors_wrap", vec_w, INIT);
    chk("midreset_busy", 74'(busy_c), 74'(0));
    chk("midreset_overrun", 74'(ovr_c), 74'(0));

    run_frame(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    run_frame(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
